// File: rtl/lvds_rx_word_aligner.sv
// Purpose : K28.5 comma word aligner behind the LVDS deserializer; picks the bit offset, confirms framing, tracks lock.
// Latency : 1 cycle from an rx_valid word to its aligned_* outputs; locked/lock_lost registered alongside.
// Backpressure: none (PHY cannot be stalled); rx_valid=0 freezes all state and drops aligned_valid next cycle.
//
// Ports:
//   clk, reset      word clock, synchronous active-high reset
//   rx_data/valid   raw 10-bit word from the deserializer, bit 0 received first
//   aligned_*       symbol-aligned word, its valid, and a K28.5 flag
//   locked          aligner is in LOCKED
//   align_offset    selected bit offset 0..9
//   lock_lost       single-cycle pulse on LOCKED -> SEARCH
//   miss_err_cnt    missed frame-start comma count, built only with LVDS_ALIGN_ERR_CNT_EN
//                   (otherwise tied to zero)
module lvds_rx_word_aligner #(
    parameter int FRAME_LEN = 16,
    parameter int LOCK_CNT  = 4,
    parameter int LOSS_CNT  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  rx_data,
    input  logic        rx_valid,
    output logic [9:0]  aligned_data,
    output logic        aligned_valid,
    output logic        aligned_comma,
    output logic        locked,
    output logic [3:0]  align_offset,
    output logic        lock_lost,
    output logic [15:0] miss_err_cnt
);

    localparam logic [7:0] FRAME_LEN_W = 8'(FRAME_LEN);
    localparam logic [3:0] LOCK_CNT_W  = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_CNT_W  = 4'(LOSS_CNT);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t      state;
    logic [9:0]  prev_word;
    logic [7:0]  wcnt;
    logic [3:0]  vcnt;
    logic [3:0]  mcnt;

    logic [19:0] win;
    logic [9:0]  comma_hit;
    logic        any_hit;
    logic [3:0]  hit_off;
    logic [9:0]  cur_slice;
    logic        cur_match;
    logic        frame_start;

    function automatic logic is_k285(input logic [9:0] w);
        return (w == 10'b0011111010) || (w == 10'b1100000101);
    endfunction

    // Older word sits in the low half so a slice at offset o reads the
    // stream starting o bits into the previous word.
    always_comb begin
        win       = {rx_data, prev_word};
        comma_hit = '0;
        hit_off   = '0;
        cur_slice = '0;
        cur_match = 1'b0;
        // Descending scan: the last assignment is the lowest matching offset.
        for (int o = 9; o >= 0; o--) begin
            comma_hit[o] = is_k285(win[o +: 10]);
            if (comma_hit[o]) begin
                hit_off = 4'(o);
            end
            if (align_offset == 4'(o)) begin
                cur_slice = win[o +: 10];
                cur_match = comma_hit[o];
            end
        end
        any_hit     = |comma_hit;
        frame_start = (wcnt == FRAME_LEN_W);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_SEARCH;
            prev_word     <= '0;
            wcnt          <= '0;
            vcnt          <= '0;
            mcnt          <= '0;
            aligned_data  <= '0;
            aligned_valid <= 1'b0;
            aligned_comma <= 1'b0;
            locked        <= 1'b0;
            align_offset  <= '0;
            lock_lost     <= 1'b0;
        end else begin
            aligned_valid <= rx_valid;
            lock_lost     <= 1'b0;
            if (rx_valid) begin
                prev_word     <= rx_data;
                // Output uses the offset in force before this word's decision.
                aligned_data  <= cur_slice;
                aligned_comma <= cur_match;
                wcnt          <= wcnt + 8'd1;
                case (state)
                    S_SEARCH: begin
                        if (any_hit) begin
                            align_offset <= hit_off;
                            wcnt         <= 8'd1;
                            vcnt         <= 4'd1;
                            mcnt         <= '0;
                            if (LOCK_CNT_W == 4'd1) begin
                                state  <= S_LOCKED;
                                locked <= 1'b1;
                            end else begin
                                state  <= S_VERIFY;
                            end
                        end
                    end
                    S_VERIFY: begin
                        if (frame_start && cur_match) begin
                            wcnt <= 8'd1;
                            vcnt <= vcnt + 4'd1;
                            if (vcnt + 4'd1 == LOCK_CNT_W) begin
                                state  <= S_LOCKED;
                                locked <= 1'b1;
                                mcnt   <= '0;
                            end
                        end else if (any_hit) begin
                            // Comma off-offset or too early: restart confirmation there.
                            align_offset <= hit_off;
                            wcnt         <= 8'd1;
                            vcnt         <= 4'd1;
                        end else if (frame_start) begin
                            state <= S_SEARCH;
                        end
                    end
                    S_LOCKED: begin
                        // Framing is free-running once locked; mid-frame commas are ignored.
                        if (frame_start) begin
                            wcnt <= 8'd1;
                            if (cur_match) begin
                                mcnt <= '0;
                            end else if (mcnt + 4'd1 == LOSS_CNT_W) begin
                                state     <= S_SEARCH;
                                locked    <= 1'b0;
                                lock_lost <= 1'b1;
                                mcnt      <= '0;
                            end else begin
                                mcnt <= mcnt + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state  <= S_SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef LVDS_ALIGN_ERR_CNT_EN
    logic        miss_evt;
    logic [15:0] miss_err_q;

    assign miss_evt = rx_valid && (state == S_LOCKED) && frame_start && !cur_match;

    // Survives loss of lock; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            miss_err_q <= '0;
        end else if (miss_evt && (miss_err_q != 16'hFFFF)) begin
            miss_err_q <= miss_err_q + 16'd1;
        end
    end

    assign miss_err_cnt = miss_err_q;
`else
    assign miss_err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_lvds_rx_word_aligner.sv
module tb_lvds_rx_word_aligner;

    localparam int FRAME_LEN = 16;
    localparam int LOCK_CNT  = 4;
    localparam int LOSS_CNT  = 3;
    localparam int K_POS     = 'h0FA;   // 10'b0011111010
    localparam int K_NEG     = 'h305;   // 10'b1100000101
    localparam int MAXW      = 512;
`ifdef LVDS_ALIGN_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rx_data;
    logic        rx_valid;
    logic [9:0]  aligned_data;
    logic        aligned_valid;
    logic        aligned_comma;
    logic        locked;
    logic [3:0]  align_offset;
    logic        lock_lost;
    logic [15:0] miss_err_cnt;

    lvds_rx_word_aligner #(
        .FRAME_LEN(FRAME_LEN),
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .aligned_data (aligned_data),
        .aligned_valid(aligned_valid),
        .aligned_comma(aligned_comma),
        .locked       (locked),
        .align_offset (align_offset),
        .lock_lost    (lock_lost),
        .miss_err_cnt (miss_err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: link mode plus frame/confirm/miss bookkeeping.
    localparam int M_SEARCH = 0, M_VERIFY = 1, M_LOCKED = 2;
    int m_mode, m_prev, m_off, m_wcnt, m_conf, m_miss;
    int e_data, e_valid, e_comma, e_locked, e_lost, e_err;

    // Stimulus stream: words, protected-bit masks, intended comma positions per window.
    logic [9:0] sw   [0:MAXW-1];
    logic [9:0] sp   [0:MAXW-1];
    logic [9:0] want [0:MAXW-1];
    int n_words;

    int obs_data [0:MAXW-1];
    int obs_comma[0:MAXW-1];
    int obs_off  [0:MAXW-1];
    int obs_lock [0:MAXW-1];
    int obs_err  [0:MAXW-1];
    int rises[$];
    int lost_cnt, lost_idx, cur_idx;
    bit prev_locked;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit is_k(input int w);
        return (w == K_POS) || (w == K_NEG);
    endfunction

    function automatic int first_comma(input int win);
        for (int o = 0; o < 10; o++) begin
            if (is_k((win >> o) & 1023)) return o;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = M_SEARCH; m_prev = 0; m_off = 0; m_wcnt = 0; m_conf = 0; m_miss = 0;
        e_data = 0; e_valid = 0; e_comma = 0; e_locked = 0; e_lost = 0; e_err = 0;
    endtask

    task automatic model_step(input int d, input bit v);
        int win, first;
        bit fs;
        e_valid = v;
        e_lost  = 0;
        if (v) begin
            win    = (d << 10) | m_prev;
            m_prev = d;
            e_data  = (win >> m_off) & 1023;
            e_comma = is_k(e_data);
            first   = first_comma(win);
            fs      = (m_wcnt == FRAME_LEN);
            m_wcnt  = (m_wcnt + 1) % 256;
            if (m_mode == M_SEARCH) begin
                if (first >= 0) begin
                    m_off = first; m_wcnt = 1; m_conf = 1; m_miss = 0;
                    m_mode = (LOCK_CNT == 1) ? M_LOCKED : M_VERIFY;
                end
            end else if (m_mode == M_VERIFY) begin
                if (fs && e_comma) begin
                    m_wcnt = 1;
                    m_conf++;
                    if (m_conf == LOCK_CNT) begin
                        m_mode = M_LOCKED; m_miss = 0;
                    end
                end else if (first >= 0) begin
                    m_off = first; m_wcnt = 1; m_conf = 1;
                end else if (fs) begin
                    m_mode = M_SEARCH;
                end
            end else begin
                if (fs) begin
                    m_wcnt = 1;
                    if (e_comma) begin
                        m_miss = 0;
                    end else begin
                        m_miss++;
                        if (ERR_EN && e_err < 65535) e_err++;
                        if (m_miss == LOSS_CNT) begin
                            m_mode = M_SEARCH; e_lost = 1; m_miss = 0;
                        end
                    end
                end
            end
            e_locked = (m_mode == M_LOCKED);
        end
    endtask

    task automatic check_all();
        chk("aligned_valid", 32'(aligned_valid), e_valid);
        chk("aligned_data",  32'(aligned_data),  e_data);
        chk("aligned_comma", 32'(aligned_comma), e_comma);
        chk("locked",        32'(locked),        e_locked);
        chk("align_offset",  32'(align_offset),  m_off);
        chk("lock_lost",     32'(lock_lost),     e_lost);
        chk("miss_err_cnt",  32'(miss_err_cnt),  e_err);
    endtask

    task automatic step(input logic [9:0] d, input bit v);
        @(negedge clk);
        rx_data  = d;
        rx_valid = v;
        model_step(int'(d), v);
        @(posedge clk);
        #1;
        check_all();
        if (lock_lost === 1'b1) begin
            lost_cnt++;
            lost_idx = cur_idx;
        end
        if (locked === 1'b1 && !prev_locked) rises.push_back(cur_idx);
        prev_locked = (locked === 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
        rises.delete();
        lost_cnt = 0; lost_idx = -1; prev_locked = 1'b0;
    endtask

    task automatic new_stream(input int n);
        n_words = n;
        for (int i = 0; i < MAXW; i++) begin
            sw[i] = 10'($urandom); sp[i] = '0; want[i] = '0;
        end
    endtask

    // Comma laid into the bit stream starting s bits into word k; seen in window k+1 at offset s.
    task automatic put_comma(input int k, input int s, input bit neg);
        int pat, pos;
        pat = neg ? K_NEG : K_POS;
        for (int j = 0; j < 10; j++) begin
            pos = 10 * k + s + j;
            sw[pos / 10][pos % 10] = pat[j];
            sp[pos / 10][pos % 10] = 1'b1;
        end
        want[k + 1][s] = 1'b1;
    endtask

    // Re-randomize filler bits until only the planted commas exist.
    task automatic clean_stream();
        int win, pw;
        bit dirty;
        for (int pass = 0; pass < 500; pass++) begin
            dirty = 1'b0;
            for (int k = 0; k < n_words; k++) begin
                pw  = (k == 0) ? 0 : int'(sw[k - 1]);
                win = (int'(sw[k]) << 10) | pw;
                for (int o = 0; o < 10; o++) begin
                    if (is_k((win >> o) & 1023) && !want[k][o]) begin
                        dirty = 1'b1;
                        sw[k] = (sw[k] & sp[k]) | (10'($urandom) & ~sp[k]);
                        if (k > 0) sw[k - 1] = (sw[k - 1] & sp[k - 1]) | (10'($urandom) & ~sp[k - 1]);
                    end
                end
            end
            if (!dirty) break;
        end
    endtask

    task automatic drive_stream(input bit toggle);
        for (int i = 0; i < n_words; i++) begin
            cur_idx = i;
            step(sw[i], 1'b1);
            obs_data[i]  = int'(aligned_data);
            obs_comma[i] = int'(aligned_comma);
            obs_off[i]   = int'(align_offset);
            obs_lock[i]  = int'(locked);
            obs_err[i]   = int'(miss_err_cnt);
            if (toggle) step(10'($urandom), 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = '0;
        cur_idx = 0;
        do_reset();
        chk("reset_locked", 32'(locked), 0);
        chk("reset_valid",  32'(aligned_valid), 0);

        // Offset 3 for six frames, then the stream slips to offset 7.
        new_stream(2 + 16 * 14);
        for (int f = 0; f < 6; f++)  put_comma(2 + 16 * f, 3, 1'b0);
        for (int f = 6; f < 14; f++) put_comma(2 + 16 * f, 7, 1'($urandom));
        clean_stream();
        drive_stream(1'b0);
        chk("s1_rise_count", rises.size(), 2);
        if (rises.size() == 2) begin
            chk("s1_lock_rise",  rises[0], 51);
            chk("s2_relock",     rises[1], 195);
        end
        chk("s1_offset",      obs_off[60], 3);
        chk("s1_frame_data",  obs_data[67], 10'b0011111010);
        chk("s1_frame_comma", obs_comma[67], 1);
        chk("s2_lost_pulses", lost_cnt, 1);
        chk("s2_lost_idx",    lost_idx, 131);
        chk("s2_unlocked",    obs_lock[131], 0);
        chk("s2_offset",      32'(align_offset), 7);

        // Reset mid-frame while locked with a word in flight.
        chk("s3_pre_locked", 32'(locked), 1);
        do_reset();
        chk("s3_locked", 32'(locked), 0);
        chk("s3_valid",  32'(aligned_valid), 0);
        chk("s3_offset", 32'(align_offset), 0);

        // Acquisition with rx_valid toggling every cycle.
        new_stream(2 + 16 * 6);
        for (int f = 0; f < 6; f++) put_comma(2 + 16 * f, 5, 1'($urandom));
        clean_stream();
        drive_stream(1'b1);
        chk("s4_rise_count", rises.size(), 1);
        if (rises.size() == 1) chk("s4_lock_rise", rises[0], 51);
        chk("s4_lost", lost_cnt, 0);
        chk("s4_offset", 32'(align_offset), 5);

        // Stray commas: word 5 of a frame in VERIFY, then in LOCKED.
        do_reset();
        new_stream(100);
        for (int f = 0; f < 7; f++) put_comma(2 + 16 * f, 2, 1'($urandom));
        put_comma(23, 6, 1'($urandom));
        put_comma(87, 2, 1'($urandom));
        clean_stream();
        drive_stream(1'b0);
        chk("s5_stray_off",    obs_off[24], 6);
        chk("s5_early_off",    obs_off[35], 2);
        chk("s5_rise_count",   rises.size(), 1);
        if (rises.size() == 1) chk("s5_lock_rise", rises[0], 83);
        chk("s5_locked_stray", obs_lock[88], 1);
        chk("s5_stray_comma",  obs_comma[88], 1);
        chk("s5_lost",         lost_cnt, 0);

        // Two misses then one good comma, repeated.
        do_reset();
        new_stream(2 + 16 * 13);
        put_comma(2, 4, 1'($urandom));
        for (int f = 1; f < 13; f++) begin
            if (f < 4 || f % 3 == 0) put_comma(2 + 16 * f, 4, 1'($urandom));
        end
        clean_stream();
        drive_stream(1'b0);
        chk("s6_err_a",   obs_err[83],  ERR_EN ? 2 : 0);
        chk("s6_err_b",   obs_err[131], ERR_EN ? 4 : 0);
        chk("s6_err_c",   obs_err[179], ERR_EN ? 6 : 0);
        chk("s6_locked",  32'(locked), 1);
        chk("s6_lost",    lost_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
